// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file, register 0 hardwired to zero, with a bulk-clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// state | meaning
// IDLE  | normal operation, writes accepted, Clear starts a sweep
// SWEEP | one register cleared per cycle from 1 up to DEPTH-1, writes dropped
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
  input  logic [ADDR_WIDTH-1:0]          WriteRegister,
  input  logic [DATA_WIDTH-1:0]          WriteData,
  input  logic                           RegWrite,
  input  logic                           Clear,
  output logic                           ClearBusy,
  output logic                           ClearDone
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {IDLE, SWEEP} stateT;

  stateT                  state;
  logic [ADDR_WIDTH-1:0]  sweepCnt;
  logic                   clearDoneQ;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state      <= IDLE;
      sweepCnt   <= ONE;
      clearDoneQ <= 1'b0;
    end else begin
      clearDoneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (RegWrite && (WriteRegister != '0)) mem[WriteRegister] <= WriteData;
          if (Clear) begin
            state    <= SWEEP;
            sweepCnt <= ONE;
          end
        end
        SWEEP: begin
          mem[sweepCnt] <= '0;
          if (sweepCnt == LAST) begin
            state      <= IDLE;
            clearDoneQ <= 1'b1;
            sweepCnt   <= ONE;
          end else begin
            sweepCnt <= sweepCnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ClearBusy = (state == SWEEP);
  assign ClearDone = clearDoneQ;

  for (genvar p = 0; p < NUM_READ; p++) begin : gRead
    logic [ADDR_WIDTH-1:0] rAddr;
    logic [DATA_WIDTH-1:0] rData;

    assign rAddr = ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rData = '0;
      if (rAddr != '0) begin
`ifdef REGFILE_BYPASS_EN
        // rAddr is nonzero here, so a match also implies WriteRegister != 0
        if (RegWrite && (state == IDLE) && (rAddr == WriteRegister)) rData = WriteData;
        else rData = mem[rAddr];
`else
        rData = mem[rAddr];
`endif
      end
    end

    assign ReadData[p*DATA_WIDTH +: DATA_WIDTH] = rData;
  end

endmodule
